// File: rtl/arith_pkg.sv
// Shared constants and per-stage record for the carry-select subtractor pipeline.
// A stage record travels with its operands, partially resolved difference and carry.
package arith_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [WIDTH_DEF-1:0] diff;
  } stage_t;

endpackage

// File: rtl/csel_slice4.sv
// One SLICE-bit slice of a + ~b: both carry-in sums are formed, then the incoming carry selects.
// Purely combinational; no state, no flow control.
module csel_slice4 import arith_pkg::*; #(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout
);

  logic [SLICE:0] w_sum0;
  logic [SLICE:0] w_sum1;

  assign w_sum0 = {1'b0, i_a} + {1'b0, ~i_b};
  assign w_sum1 = {1'b0, i_a} + {1'b0, ~i_b} + {{SLICE{1'b0}}, 1'b1};

  assign {o_cout, o_sum} = i_cin ? w_sum1 : w_sum0;

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined a - b - bin, one SLICE-bit carry-select slice per stage; result valid STAGES cycles after acceptance.
// Valid/ready chain: a stage moves when empty or its successor moves; in_ready falls only when every stage is full and stalled.
module pipelined_subtractor import arith_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int MSB    = WIDTH - 1;

  stage_t              r_stg [STAGES];
  stage_t              w_nxt [STAGES];
  logic [STAGES-1:0]   w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_prev;
    stage_t           w_cur;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;

    if (k == 0) begin : g_head
      // Subtraction as a + ~b + ~bin: the borrow-in becomes an inverted carry-in.
      always_comb begin
        w_prev       = '0;
        w_prev.valid = in_valid;
        w_prev.carry = !bin;
        w_prev.a     = a;
        w_prev.b     = b;
      end
    end else begin : g_body
      assign w_prev = r_stg[k-1];
    end

    csel_slice4 #(.SLICE(SLICE)) u_slice (
      .i_a    (w_prev.a[k*SLICE +: SLICE]),
      .i_b    (w_prev.b[k*SLICE +: SLICE]),
      .i_cin  (w_prev.carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
    );

    always_comb begin
      w_cur                        = w_prev;
      w_cur.carry                  = w_cout;
      w_cur.diff[k*SLICE +: SLICE] = w_sum;
    end

    assign w_nxt[k] = w_cur;
  end

  always_comb begin : p_adv
    logic w_go;
    w_adv = '0;
    w_go  = !r_stg[STAGES-1].valid || out_ready;
    w_adv[STAGES-1] = w_go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_go     = !r_stg[k].valid || w_go;
      w_adv[k] = w_go;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) r_stg[k] <= w_nxt[k];
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_stg[STAGES-1].valid;
  assign diff      = r_stg[STAGES-1].diff;
  // Borrow is the inverted final carry; gated so an empty output reads 0.
  assign bout      = r_stg[STAGES-1].valid && !r_stg[STAGES-1].carry;
  assign ovf       = (r_stg[STAGES-1].a[MSB] != r_stg[STAGES-1].b[MSB]) &&
                     (r_stg[STAGES-1].diff[MSB] != r_stg[STAGES-1].a[MSB]);

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed and random checks of the pipelined subtractor against hand-computed vectors and a plain a-b-bin model.
module tb_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_subtractor #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // {ovf, bout, diff} from straightforward 17-bit subtraction
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    logic [16:0] full;
    logic        ov;
    full = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    ov   = (ma[15] != mb[15]) && (full[15] != ma[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  task automatic push(input logic [15:0] pa, input logic [15:0] pb, input logic pbin, output bit to);
    int n;
    @(posedge clk); #1;
    a = pa; b = pb; bin = pbin; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    to = !in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(output logic [17:0] got, output bit to);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    to  = !out_valid;
    got = {ovf, bout, diff};
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL reset_diff: got %h expected 0000", diff); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b expected 0", bout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency;
    bit   to;
    logic expv;
    push(16'h1234, 16'h0034, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL lat_accept: got timeout expected acceptance"); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      expv = (i == 4);
      n_checks++;
      if (out_valid !== expv) begin n_fail++; $display("FAIL lat_out_valid cycle %0d: got %b expected %b", i, out_valid, expv); end
    end
    n_checks++;
    if ({ovf, bout, diff} !== 18'h01200) begin
      n_fail++; $display("FAIL lat_result: got ovf=%b bout=%b diff=%h expected ovf=0 bout=0 diff=1200", ovf, bout, diff);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_no_dup: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_borrow;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic        vbin [2];
    logic [17:0] ve [2];
    logic [17:0] got;
    bit          to_i, to_o;
    va[0] = 16'h0000; vb[0] = 16'h0001; vbin[0] = 1'b0; ve[0] = 18'h1FFFF;
    va[1] = 16'h0005; vb[1] = 16'h0005; vbin[1] = 1'b1; ve[1] = 18'h1FFFF;
    for (int i = 0; i < 2; i++) begin
      push(va[i], vb[i], vbin[i], to_i);
      collect(got, to_o);
      n_checks++;
      if (to_i || to_o || got !== ve[i]) begin
        n_fail++; $display("FAIL borrow_%0d: got {ovf,bout,diff}=%h timeout=%b expected %h", i, got, to_i | to_o, ve[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [17:0] ve [2];
    logic [17:0] got;
    bit          to_i, to_o;
    va[0] = 16'h8000; vb[0] = 16'h0001; ve[0] = 18'h27FFF;
    va[1] = 16'h7FFF; vb[1] = 16'hFFFF; ve[1] = 18'h38000;
    for (int i = 0; i < 2; i++) begin
      push(va[i], vb[i], 1'b0, to_i);
      collect(got, to_o);
      n_checks++;
      if (to_i || to_o || got !== ve[i]) begin
        n_fail++; $display("FAIL overflow_%0d: got {ovf,bout,diff}=%h timeout=%b expected %h", i, got, to_i | to_o, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vbin [6];
    logic [17:0] ve [6];
    int          ii, oi, cyc;
    bit          took_in, took_out;
    va[0] = 16'h0010; vb[0] = 16'h0001; vbin[0] = 1'b0; ve[0] = 18'h0000F;
    va[1] = 16'h0100; vb[1] = 16'h0010; vbin[1] = 1'b0; ve[1] = 18'h000F0;
    va[2] = 16'h1000; vb[2] = 16'h0100; vbin[2] = 1'b0; ve[2] = 18'h00F00;
    va[3] = 16'hFFFF; vb[3] = 16'h0001; vbin[3] = 1'b1; ve[3] = 18'h0FFFD;
    va[4] = 16'h0002; vb[4] = 16'h0003; vbin[4] = 1'b0; ve[4] = 18'h1FFFF;
    va[5] = 16'h4000; vb[5] = 16'hC000; vbin[5] = 1'b0; ve[5] = 18'h38000;
    ii = 0; oi = 0; cyc = 0;
    @(posedge clk); #1;
    while (oi < 6 && cyc < 40) begin
      out_ready = (cyc >= 6);
      in_valid  = (ii < 6);
      if (ii < 6) begin a = va[ii]; b = vb[ii]; bin = vbin[ii]; end
      @(negedge clk);
      if (cyc < 4 || cyc == 6) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cycle %0d: got %b expected 1", cyc, in_ready); end
      end else if (cyc < 6) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full cycle %0d: got in_ready %b expected 0", cyc, in_ready); end
        n_checks++; if (ii !== 4) begin n_fail++; $display("FAIL b2b_accepted cycle %0d: got %0d expected 4", cyc, ii); end
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, bout, diff} !== ve[0]) begin
          n_fail++; $display("FAIL b2b_hold cycle %0d: got valid=%b {ovf,bout,diff}=%h expected valid=1 %h", cyc, out_valid, {ovf, bout, diff}, ve[0]);
        end
      end
      took_in  = in_valid && in_ready;
      took_out = out_valid && out_ready;
      if (took_out) begin
        n_checks++;
        if ({ovf, bout, diff} !== ve[oi]) begin
          n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", oi, {ovf, bout, diff}, ve[oi]);
        end
        oi++;
      end
      @(posedge clk); #1;
      if (took_in) ii++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (oi != 6) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 6", oi); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    int seen;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'hA000 + 16'(i); b = 16'h0001; bin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d stale results expected 0", seen); end
  endtask

  task automatic test_random;
    logic [17:0] q [$];
    logic [17:0] held;
    logic [17:0] exp_r;
    bit          hold_prev;
    int          sent, cyc;
    sent = 0; cyc = 0; hold_prev = 1'b0; held = '0;
    @(posedge clk); #1;
    while ((sent < 10000 || q.size() != 0) && cyc < 40000) begin
      if (sent < 10000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (sent >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (hold_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, bout, diff} !== held) begin
          n_fail++; $display("FAIL rand_hold: got valid=%b %h expected valid=1 %h", out_valid, {ovf, bout, diff}, held);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got result %h expected none", {ovf, bout, diff});
        end else begin
          exp_r = q.pop_front();
          if ({ovf, bout, diff} !== exp_r) begin
            n_fail++; $display("FAIL rand_result: got %h expected %h", {ovf, bout, diff}, exp_r);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = {ovf, bout, diff};
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (sent != 10000 || q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got sent=%0d pending=%0d expected 10000 and 0", sent, q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    test_reset;
    test_latency;
    test_borrow;
    test_overflow;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
